// File: rtl/mips_reg_file_if.sv
// mips_reg_file_if
//   Bus interface for the HDU-MIPS register file. It bundles two asynchronous
//   read ports, one synchronous write port, a debug read port and the write
//   counter.
//
//   Signals:
//     raddr_a / rdata_a   read port A (rs), feeds the ALU A operand
//     raddr_b / rdata_b   read port B (rt), feeds the ALU B operand
//     we, waddr, wdata    write port (writeback stage)
//     dbg_addr / dbg_data debug read port (board switches / LEDs), never bypassed
//     wr_cnt              count of accepted writes to non-zero registers (wraps)
//
//   Modports:
//     master  the datapath / testbench side that drives addresses and write data
//     slave   the register file itself
`timescale 1ns/1ps

interface mips_reg_file_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);

  logic [ADDR_W-1:0] raddr_a;
  logic [ADDR_W-1:0] raddr_b;
  logic [DATA_W-1:0] rdata_a;
  logic [DATA_W-1:0] rdata_b;

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;

  logic [7:0]        wr_cnt;

  modport master (
    output raddr_a, raddr_b, we, waddr, wdata, dbg_addr,
    input  rdata_a, rdata_b, dbg_data, wr_cnt
  );

  modport slave (
    input  raddr_a, raddr_b, we, waddr, wdata, dbg_addr,
    output rdata_a, rdata_b, dbg_data, wr_cnt
  );

endinterface

// File: rtl/mips_reg_file.sv
// mips_reg_file
//   Register file for the HDU-MIPS datapath, sitting directly upstream of
//   ALU_Top. Register 0 is hard-wired to zero.
//
//   Parameters:
//     DATA_W  width of each register and data port
//     ADDR_W  address width; 2**ADDR_W registers
//     BYPASS  1 = a same-cycle write is forwarded to read ports A/B
//             0 = reads of the register being written return the old value
//
//   Ports:
//     clk     system clock, writes commit on the rising edge
//     rst_n   asynchronous active-low reset; clears every register and wr_cnt.
//             Deassertion must be synchronised by the top level.
//     bus     mips_reg_file_if.slave: read ports A/B (combinational),
//             write port, debug read port (committed state only), wr_cnt
`timescale 1ns/1ps

module mips_reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  mips_reg_file_if.slave bus
);

  localparam int NUM_REGS = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [7:0]        wr_cnt_q;
  logic [7:0]        wr_cnt_d;

  logic              wr_fire;
  logic              byp_a;
  logic              byp_b;

  // A write only counts when it targets a real register; writes to r0 vanish.
  always_comb begin
    wr_fire = bus.we && (bus.waddr != '0);
  end

  // Next-state for the array and counter. r0 is forced to zero so it can
  // never hold anything other than 0 regardless of what reaches it.
  always_comb begin
    regs_d   = regs_q;
    wr_cnt_d = wr_cnt_q;
    if (wr_fire) begin
      regs_d[bus.waddr] = bus.wdata;
      wr_cnt_d          = wr_cnt_q + 8'd1;
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      wr_cnt_q <= '0;
    end else begin
      regs_q   <= regs_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  // Forwarding select. Gated by rst_n so that all outputs read zero while
  // reset is held, even if a write is being presented at the same time.
  always_comb begin
    byp_a = 1'b0;
    byp_b = 1'b0;
    if (BYPASS != 0) begin
      byp_a = rst_n && wr_fire && (bus.raddr_a == bus.waddr);
      byp_b = rst_n && wr_fire && (bus.raddr_b == bus.waddr);
    end
  end

  always_comb begin
    bus.rdata_a = (bus.raddr_a == '0) ? '0 : regs_q[bus.raddr_a];
    if (byp_a) begin
      bus.rdata_a = bus.wdata;
    end
  end

  always_comb begin
    bus.rdata_b = (bus.raddr_b == '0) ? '0 : regs_q[bus.raddr_b];
    if (byp_b) begin
      bus.rdata_b = bus.wdata;
    end
  end

  // Debug port shows committed state only, so the board display never
  // flickers with an in-flight write.
  always_comb begin
    bus.dbg_data = (bus.dbg_addr == '0) ? '0 : regs_q[bus.dbg_addr];
  end

  always_comb begin
    bus.wr_cnt = wr_cnt_q;
  end

endmodule

// File: tb/tb_mips_reg_file.sv
// tb_mips_reg_file
//   Bench for mips_reg_file. Two instances share identical stimulus: one with
//   BYPASS=1, one with BYPASS=0. Expected values come from a small reference
//   model (model_regs / model_cnt) and spec constants, pushed to a scoreboard
//   queue when stimulus is driven and popped when the outputs are sampled.
`timescale 1ns/1ps

module tb_mips_reg_file;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  mips_reg_file_if #(.DATA_W(32), .ADDR_W(5)) byp_if ();
  mips_reg_file_if #(.DATA_W(32), .ADDR_W(5)) nob_if ();

  mips_reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut_byp (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (byp_if.slave)
  );

  mips_reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) dut_nob (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (nob_if.slave)
  );

  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] sb_q [$];
  logic [31:0] model_regs [32];
  logic [7:0]  model_cnt;

  function automatic logic [31:0] pat(input logic [4:0] a);
    return {8'hA5, 3'b000, a, 8'h5A, 3'b000, a};
  endfunction

  task automatic drive(input logic w_en, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] da);
    byp_if.we = w_en;  byp_if.waddr = wa;  byp_if.wdata = wd;
    byp_if.raddr_a = ra; byp_if.raddr_b = rb; byp_if.dbg_addr = da;
    nob_if.we = w_en;  nob_if.waddr = wa;  nob_if.wdata = wd;
    nob_if.raddr_a = ra; nob_if.raddr_b = rb; nob_if.dbg_addr = da;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model_regs[i] = '0;
    model_cnt = '0;
  endtask

  // Present a write for one full clock, commit on the posedge, update the model.
  task automatic do_write(input logic [4:0] wa, input logic [31:0] wd);
    @(negedge clk);
    drive(1'b1, wa, wd, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    if (wa != 5'd0) begin
      model_regs[wa] = wd;
      model_cnt      = model_cnt + 8'd1;
    end
  endtask

  task automatic test_reset();
    logic [31:0] exp;
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 5'd3, 5'd4, 5'd5);
    model_reset();
    sb_q.push_back(32'd0); sb_q.push_back(32'd0); sb_q.push_back(32'd0);
    #2;
    exp = sb_q.pop_front(); vectors++;
    if (byp_if.rdata_a !== exp) begin miscompares++; $display("FAIL por_rdata_a: got %h expected %h", byp_if.rdata_a, exp); end
    exp = sb_q.pop_front(); vectors++;
    if (byp_if.dbg_data !== exp) begin miscompares++; $display("FAIL por_dbg: got %h expected %h", byp_if.dbg_data, exp); end
    exp = sb_q.pop_front(); vectors++;
    if (byp_if.wr_cnt !== exp[7:0]) begin miscompares++; $display("FAIL por_wr_cnt: got %0d expected %0d", byp_if.wr_cnt, exp[7:0]); end

    @(negedge clk);
    rst_n = 1'b1;
    for (int a = 1; a < 32; a++) do_write(a[4:0], pat(a[4:0]));

    drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd17);
    sb_q.push_back({24'd0, model_cnt});
    sb_q.push_back(model_regs[17]);
    #1;
    exp = sb_q.pop_front(); vectors++;
    if (byp_if.wr_cnt !== exp[7:0]) begin miscompares++; $display("FAIL fill_wr_cnt: got %0d expected %0d", byp_if.wr_cnt, exp[7:0]); end
    exp = sb_q.pop_front(); vectors++;
    if (byp_if.dbg_data !== exp) begin miscompares++; $display("FAIL fill_dbg17: got %h expected %h", byp_if.dbg_data, exp); end

    // Pulse reset in the low phase of the clock: no edge before the first check.
    @(negedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    for (int a = 0; a < 32; a++) begin
      drive(1'b0, 5'd0, 32'd0, a[4:0], 5'(31 - a), a[4:0]);
      sb_q.push_back(model_regs[a]);
      sb_q.push_back(model_regs[31 - a]);
      sb_q.push_back(model_regs[a]);
      #0.5;
      exp = sb_q.pop_front(); vectors++;
      if (byp_if.rdata_a !== exp) begin miscompares++; $display("FAIL rst_rdata_a[%0d]: got %h expected %h", a, byp_if.rdata_a, exp); end
      exp = sb_q.pop_front(); vectors++;
      if (byp_if.rdata_b !== exp) begin miscompares++; $display("FAIL rst_rdata_b[%0d]: got %h expected %h", 31 - a, byp_if.rdata_b, exp); end
      exp = sb_q.pop_front(); vectors++;
      if (nob_if.dbg_data !== exp) begin miscompares++; $display("FAIL rst_dbg[%0d]: got %h expected %h", a, nob_if.dbg_data, exp); end
    end
    sb_q.push_back({24'd0, model_cnt});
    exp = sb_q.pop_front(); vectors++;
    if (byp_if.wr_cnt !== exp[7:0]) begin miscompares++; $display("FAIL rst_wr_cnt: got %0d expected %0d", byp_if.wr_cnt, exp[7:0]); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    logic [31:0] exp;
    do_write(5'd5,  32'h1234_5678);
    do_write(5'd31, 32'hFFFF_FFFF);
    drive(1'b0, 5'd0, 32'd0, 5'd5, 5'd31, 5'd5);
    sb_q.push_back(32'h1234_5678);
    sb_q.push_back(32'hFFFF_FFFF);
    sb_q.push_back(32'd2);
    #1;
    exp = sb_q.pop_front(); vectors++;
    if (byp_if.rdata_a !== exp) begin miscompares++; $display("FAIL wr_rd_a5: got %h expected %h", byp_if.rdata_a, exp); end
    exp = sb_q.pop_front(); vectors++;
    if (nob_if.rdata_b !== exp) begin miscompares++; $display("FAIL wr_rd_b31: got %h expected %h", nob_if.rdata_b, exp); end
    exp = sb_q.pop_front(); vectors++;
    if (byp_if.wr_cnt !== exp[7:0]) begin miscompares++; $display("FAIL wr_rd_cnt: got %0d expected %0d", byp_if.wr_cnt, exp[7:0]); end

    // we=0 with live write data across an edge: nothing may change.
    @(negedge clk);
    drive(1'b0, 5'd5, 32'hCAFE_F00D, 5'd5, 5'd31, 5'd5);
    @(negedge clk);
    sb_q.push_back(model_regs[5]);
    sb_q.push_back({24'd0, model_cnt});
    #1;
    exp = sb_q.pop_front(); vectors++;
    if (byp_if.dbg_data !== exp) begin miscompares++; $display("FAIL hold_reg5: got %h expected %h", byp_if.dbg_data, exp); end
    exp = sb_q.pop_front(); vectors++;
    if (nob_if.wr_cnt !== exp[7:0]) begin miscompares++; $display("FAIL hold_cnt: got %0d expected %0d", nob_if.wr_cnt, exp[7:0]); end
  endtask

  task automatic test_reg0();
    logic [31:0] exp;
    @(negedge clk);
    drive(1'b1, 5'd0, 32'hDEAD_BEEF, 5'd0, 5'd0, 5'd0);
    sb_q.push_back(32'd0);
    sb_q.push_back(32'd0);
    #1;
    exp = sb_q.pop_front(); vectors++;
    if (byp_if.rdata_a !== exp) begin miscompares++; $display("FAIL r0_bypass_a: got %h expected %h", byp_if.rdata_a, exp); end
    exp = sb_q.pop_front(); vectors++;
    if (byp_if.rdata_b !== exp) begin miscompares++; $display("FAIL r0_bypass_b: got %h expected %h", byp_if.rdata_b, exp); end
    @(negedge clk);
    drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    sb_q.push_back(32'd0);
    sb_q.push_back({24'd0, model_cnt});
    #1;
    exp = sb_q.pop_front(); vectors++;
    if (byp_if.dbg_data !== exp) begin miscompares++; $display("FAIL r0_after: got %h expected %h", byp_if.dbg_data, exp); end
    exp = sb_q.pop_front(); vectors++;
    if (byp_if.wr_cnt !== exp[7:0]) begin miscompares++; $display("FAIL r0_cnt: got %0d expected %0d", byp_if.wr_cnt, exp[7:0]); end
  endtask

  task automatic test_bypass();
    logic [31:0] exp;
    do_write(5'd7, 32'h0000_0001);
    @(negedge clk);
    drive(1'b1, 5'd7, 32'h0000_00AA, 5'd7, 5'd7, 5'd7);
    sb_q.push_back(32'h0000_00AA); sb_q.push_back(32'h0000_00AA); sb_q.push_back(32'h0000_0001);
    sb_q.push_back(32'h0000_0001); sb_q.push_back(32'h0000_0001);
    #1;
    exp = sb_q.pop_front(); vectors++;
    if (byp_if.rdata_a !== exp) begin miscompares++; $display("FAIL byp_a: got %h expected %h", byp_if.rdata_a, exp); end
    exp = sb_q.pop_front(); vectors++;
    if (byp_if.rdata_b !== exp) begin miscompares++; $display("FAIL byp_b: got %h expected %h", byp_if.rdata_b, exp); end
    exp = sb_q.pop_front(); vectors++;
    if (byp_if.dbg_data !== exp) begin miscompares++; $display("FAIL byp_dbg: got %h expected %h", byp_if.dbg_data, exp); end
    exp = sb_q.pop_front(); vectors++;
    if (nob_if.rdata_a !== exp) begin miscompares++; $display("FAIL nobyp_a: got %h expected %h", nob_if.rdata_a, exp); end
    exp = sb_q.pop_front(); vectors++;
    if (nob_if.rdata_b !== exp) begin miscompares++; $display("FAIL nobyp_b: got %h expected %h", nob_if.rdata_b, exp); end
    @(negedge clk);
    drive(1'b0, 5'd0, 32'd0, 5'd7, 5'd7, 5'd7);
    model_regs[7] = 32'h0000_00AA;
    model_cnt     = model_cnt + 8'd1;
    sb_q.push_back(model_regs[7]);
    sb_q.push_back(model_regs[7]);
    #1;
    exp = sb_q.pop_front(); vectors++;
    if (nob_if.rdata_a !== exp) begin miscompares++; $display("FAIL nobyp_after: got %h expected %h", nob_if.rdata_a, exp); end
    exp = sb_q.pop_front(); vectors++;
    if (byp_if.dbg_data !== exp) begin miscompares++; $display("FAIL dbg_after: got %h expected %h", byp_if.dbg_data, exp); end

    // Only port A matches the write address; port B must show stored data.
    @(negedge clk);
    drive(1'b1, 5'd9, 32'h0000_0099, 5'd9, 5'd7, 5'd9);
    sb_q.push_back(32'h0000_0099);
    sb_q.push_back(model_regs[7]);
    sb_q.push_back(model_regs[9]);
    #1;
    exp = sb_q.pop_front(); vectors++;
    if (byp_if.rdata_a !== exp) begin miscompares++; $display("FAIL byp1_a: got %h expected %h", byp_if.rdata_a, exp); end
    exp = sb_q.pop_front(); vectors++;
    if (byp_if.rdata_b !== exp) begin miscompares++; $display("FAIL byp1_b: got %h expected %h", byp_if.rdata_b, exp); end
    exp = sb_q.pop_front(); vectors++;
    if (nob_if.rdata_a !== exp) begin miscompares++; $display("FAIL nobyp1_a: got %h expected %h", nob_if.rdata_a, exp); end
    @(negedge clk);
    drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    model_regs[9] = 32'h0000_0099;
    model_cnt     = model_cnt + 8'd1;
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] exp;
    @(negedge clk);
    drive(1'b1, 5'd10, 32'h0BAD_F00D, 5'd10, 5'd10, 5'd10);
    #2 rst_n = 1'b0;
    model_reset();
    sb_q.push_back(32'd0);
    #1;
    exp = sb_q.pop_front(); vectors++;
    if (byp_if.rdata_a !== exp) begin miscompares++; $display("FAIL rstwr_bypass: got %h expected %h", byp_if.rdata_a, exp); end
    @(posedge clk);
    #1;
    sb_q.push_back(model_regs[10]);
    sb_q.push_back({24'd0, model_cnt});
    exp = sb_q.pop_front(); vectors++;
    if (byp_if.dbg_data !== exp) begin miscompares++; $display("FAIL rstwr_reg10: got %h expected %h", byp_if.dbg_data, exp); end
    exp = sb_q.pop_front(); vectors++;
    if (byp_if.wr_cnt !== exp[7:0]) begin miscompares++; $display("FAIL rstwr_cnt: got %0d expected %0d", byp_if.wr_cnt, exp[7:0]); end
    @(negedge clk);
    drive(1'b0, 5'd0, 32'd0, 5'd10, 5'd10, 5'd10);
    rst_n = 1'b1;
    sb_q.push_back(model_regs[10]);
    #1;
    exp = sb_q.pop_front(); vectors++;
    if (nob_if.rdata_a !== exp) begin miscompares++; $display("FAIL rstwr_release: got %h expected %h", nob_if.rdata_a, exp); end
  endtask

  task automatic test_counter_wrap();
    logic [31:0] exp;
    for (int i = 0; i < 256; i++) begin
      do_write(5'd1, 32'h0000_0100 + 32'(i));
      if (i == 254) begin
        sb_q.push_back({24'd0, model_cnt});
        #1;
        exp = sb_q.pop_front(); vectors++;
        if (byp_if.wr_cnt !== exp[7:0]) begin miscompares++; $display("FAIL wrap_cnt255: got %0d expected %0d", byp_if.wr_cnt, exp[7:0]); end
      end
    end
    drive(1'b0, 5'd0, 32'd0, 5'd1, 5'd0, 5'd1);
    sb_q.push_back({24'd0, model_cnt});
    sb_q.push_back(model_regs[1]);
    #1;
    exp = sb_q.pop_front(); vectors++;
    if (byp_if.wr_cnt !== exp[7:0]) begin miscompares++; $display("FAIL wrap_cnt0: got %0d expected %0d", byp_if.wr_cnt, exp[7:0]); end
    exp = sb_q.pop_front(); vectors++;
    if (byp_if.rdata_a !== exp) begin miscompares++; $display("FAIL wrap_reg1: got %h expected %h", byp_if.rdata_a, exp); end
  endtask

  task automatic test_alu_integration();
    logic [31:0] exp;
    logic [31:0] alu_f;
    logic        alu_of;
    logic        alu_zf;
    do_write(5'd1, 32'h7FFF_FFFF);
    do_write(5'd2, 32'h0000_0001);
    drive(1'b0, 5'd0, 32'd0, 5'd1, 5'd2, 5'd0);
    sb_q.push_back(32'h8000_0000);
    sb_q.push_back(32'd1);
    sb_q.push_back(32'd0);
    #1;
    // Reference ALU ADD on the register file outputs.
    alu_f  = byp_if.rdata_a + byp_if.rdata_b;
    alu_of = (byp_if.rdata_a[31] == byp_if.rdata_b[31]) && (alu_f[31] != byp_if.rdata_a[31]);
    alu_zf = (alu_f == 32'd0);
    exp = sb_q.pop_front(); vectors++;
    if (alu_f !== exp) begin miscompares++; $display("FAIL alu_F: got %h expected %h", alu_f, exp); end
    exp = sb_q.pop_front(); vectors++;
    if (alu_of !== exp[0]) begin miscompares++; $display("FAIL alu_OF: got %b expected %b", alu_of, exp[0]); end
    exp = sb_q.pop_front(); vectors++;
    if (alu_zf !== exp[0]) begin miscompares++; $display("FAIL alu_ZF: got %b expected %b", alu_zf, exp[0]); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    test_reset();
    test_write_read();
    test_reg0();
    test_bypass();
    test_reset_mid_write();
    test_counter_wrap();
    test_alu_integration();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
